imem_loader: RTL and testbench
==============================

// Module: imem_loader
// PURPOSE
//  Writer side of the instruction-memory interface the core fetches from: takes a byte stream
//  (valid/ready), assembles big-endian 32-bit instruction words and writes them sequentially
//  into instruction memory from word 0. Holds the core (cpu_hold) until a load completes.
//  Sits between the host byte link (UART RX) and the instruction memory write port.
// PARAMETERS
//  ADDR_W     6   instruction memory address width (2**ADDR_W words, 64 default)
//  MAX_WORDS  64  largest accepted program length in words (<= 2**ADDR_W)
// PORTS
//  clock       in   1       system clock, rising edge
//  reset       in   1       asynchronous reset, active-high
//  start       in   1       one-cycle pulse: begin a load (honoured in IDLE/DONE only)
//  byte_in     in   8       stream byte
//  byte_valid  in   1       byte_in valid
//  byte_ready  out  1       loader accepts byte this cycle (transfer = valid & ready)
//  mem_addr    out  ADDR_W  instruction memory write address
//  mem_data    out  32      instruction word to write
//  mem_we      out  1       write strobe, one cycle per word
//  cpu_hold    out  1       1 = core must stall; 0 only after a successful load
//  done        out  1       level: last load completed without error
//  err         out  1       level: last load aborted (bad length / checksum)
//  word_count  out  ADDR_W+1 words written in current/last load
// BEHAVIOUR
//  Reset (async): state=IDLE, byte_ready=0, mem_we=0, mem_addr=0, mem_data=0, cpu_hold=1,
//   done=0, err=0, word_count=0, byte counter=0. Memory contents untouched.
//  States: IDLE -> LEN -> DATA <-> WRITE -> (CHK) -> DONE; any error -> IDLE with err=1.
//  IDLE/DONE: byte_ready=0. start: clear done/err/word_count, cpu_hold=1, go LEN.
//  LEN: byte_ready=1; accepted byte = N words. N==0 or N>MAX_WORDS -> err=1, IDLE.
//   Else latch N, go DATA.
//  DATA: byte_ready=1; bytes shift into word, first byte -> [31:24]. On 4th accepted byte
//   go WRITE. byte_valid low simply waits (no timeout).
//  WRITE: byte_ready=0; exactly one cycle mem_we=1, mem_addr=word_count[ADDR_W-1:0],
//   mem_data=assembled word; word_count+1. If word_count reaches N: go CHK (macro on)
//   or DONE, else back to DATA. Latency: 4th byte accepted in cycle t -> mem_we in t+1.
//  DONE entry: done=1, cpu_hold=0 (registered, in same cycle as state change).
//  start in LEN/DATA/WRITE/CHK: ignored. start and byte transfer same cycle in IDLE: byte
//   ignored (byte_ready=0).
//  Reset mid-load: return to reset values; words already written remain; cpu_hold=1.
//  mem_we never asserted outside WRITE; addresses never exceed N-1 (no wrap).
// CONFIGURATION
//  IMEM_LOADER_CHECKSUM_EN defined: running XOR of all DATA bytes; after last word, state CHK
//   (byte_ready=1) accepts one byte; equal -> DONE, mismatch -> err=1, IDLE, cpu_hold stays 1
//   (written words remain). Undefined: no CHK state, DONE directly after last WRITE.
// TESTING
//  1 reset -> cpu_hold=1, done=0, err=0, mem_we=0, byte_ready=0, word_count=0.
//  2 start; bytes 02, 12,34,56,78, 9A,BC,DE,F0 -> mem_we @addr0 data 0x12345678, @addr1
//    0x9ABCDEF0, done=1, cpu_hold=0, word_count=2 (macro off).
//  3 start; length byte 00 then 0x41 -> err=1, no mem_we, cpu_hold=1, back in IDLE.
//  4 N=1 with byte_valid toggling every other cycle plus start pulses mid-load -> single
//    write 0xAABBCCDD @0, starts ignored, byte_ready=0 during WRITE cycle.
//  5 reset asserted after 2 of 4 data bytes -> immediate reset values; next start reloads ok.
//  6 macro on: N=1, 01,02,03,04 then 04 -> done=1; repeat with check 05 -> err=1, cpu_hold=1.

Source files
------------

// File: rtl/imem_loader.sv
// imem_loader: byte stream -> big-endian 32-bit words written to instruction memory from word 0, core held until done.
// Optional IMEM_LOADER_CHECKSUM_EN: trailing XOR checksum byte verified before releasing the core.
module imem_loader #(
    parameter int ADDR_W    = 6,
    parameter int MAX_WORDS = 64
) (
    input  logic              clock_i,
    input  logic              reset_i,
    input  logic              start_i,
    input  logic [7:0]        byte_in_i,
    input  logic              byte_valid_i,
    output logic              byte_ready_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [31:0]       mem_data_o,
    output logic              mem_we_o,
    output logic              cpu_hold_o,
    output logic              done_o,
    output logic              err_o,
    output logic [ADDR_W:0]   word_count_o
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN,
        S_DATA,
        S_WRITE,
`ifdef IMEM_LOADER_CHECKSUM_EN
        S_CHK,
`endif
        S_DONE
    } state_t;

    localparam logic [8:0] MAX_L = 9'(MAX_WORDS);

    state_t            state_q;
    logic              byte_ready_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [31:0]       mem_data_q;
    logic              mem_we_q;
    logic              cpu_hold_q;
    logic              done_q;
    logic              err_q;
    logic [ADDR_W:0]   wc_q;
    logic [ADDR_W:0]   len_q;
    logic [1:0]        cnt_q;
    logic [ADDR_W:0]   wc_d;
    logic              xfer;
    logic              bad_len;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]        csum_q;
`endif

    assign xfer    = byte_valid_i & byte_ready_q;
    assign bad_len = byte_in_i == 8'd0 || {1'b0, byte_in_i} > MAX_L;
    assign wc_d    = wc_q + 1'b1;

    assign byte_ready_o = byte_ready_q;
    assign mem_addr_o   = mem_addr_q;
    assign mem_data_o   = mem_data_q;
    assign mem_we_o     = mem_we_q;
    assign cpu_hold_o   = cpu_hold_q;
    assign done_o       = done_q;
    assign err_o        = err_q;
    assign word_count_o = wc_q;

    // The word is assembled directly in the data output register; it is only sampled when mem_we is high.
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            state_q      <= S_IDLE;
            byte_ready_q <= 1'b0;
            mem_addr_q   <= '0;
            mem_data_q   <= '0;
            mem_we_q     <= 1'b0;
            cpu_hold_q   <= 1'b1;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
            wc_q         <= '0;
            len_q        <= '0;
            cnt_q        <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum_q       <= '0;
`endif
        end else begin
            mem_we_q <= 1'b0;
            case (state_q)
                S_IDLE, S_DONE: if (start_i) begin
                    done_q       <= 1'b0;
                    err_q        <= 1'b0;
                    wc_q         <= '0;
                    cpu_hold_q   <= 1'b1;
                    byte_ready_q <= 1'b1;
                    state_q      <= S_LEN;
                end
                S_LEN: if (xfer) begin
                    if (bad_len) begin
                        err_q        <= 1'b1;
                        byte_ready_q <= 1'b0;
                        state_q      <= S_IDLE;
                    end else begin
                        len_q   <= (ADDR_W+1)'(byte_in_i);
                        cnt_q   <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                        csum_q  <= '0;
`endif
                        state_q <= S_DATA;
                    end
                end
                S_DATA: if (xfer) begin
                    mem_data_q <= {mem_data_q[23:0], byte_in_i};
                    cnt_q      <= cnt_q + 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
                    csum_q     <= csum_q ^ byte_in_i;
`endif
                    if (cnt_q == 2'd3) begin
                        mem_we_q     <= 1'b1;
                        mem_addr_q   <= wc_q[ADDR_W-1:0];
                        byte_ready_q <= 1'b0;
                        state_q      <= S_WRITE;
                    end
                end
                S_WRITE: begin
                    wc_q <= wc_d;
                    if (wc_d == len_q) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                        byte_ready_q <= 1'b1;
                        state_q      <= S_CHK;
`else
                        done_q       <= 1'b1;
                        cpu_hold_q   <= 1'b0;
                        state_q      <= S_DONE;
`endif
                    end else begin
                        byte_ready_q <= 1'b1;
                        state_q      <= S_DATA;
                    end
                end
`ifdef IMEM_LOADER_CHECKSUM_EN
                S_CHK: if (xfer) begin
                    byte_ready_q <= 1'b0;
                    if (byte_in_i == csum_q) begin
                        done_q     <= 1'b1;
                        cpu_hold_q <= 1'b0;
                        state_q    <= S_DONE;
                    end else begin
                        err_q   <= 1'b1;
                        state_q <= S_IDLE;
                    end
                end
`endif
                default: state_q <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: randomized byte-stream loads checked every cycle against a transaction-level model.
module tb_imem_loader;
    localparam int ADDR_W = 6;
    localparam int MAXW   = 64;

    logic              clk = 0, rst = 0, start = 0, bv = 0;
    logic [7:0]        bin = 0;
    logic              byte_ready, mem_we, cpu_hold, done, err;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_data;
    logic [ADDR_W:0]   word_count;

    imem_loader #(.ADDR_W(ADDR_W), .MAX_WORDS(MAXW)) dut (
        .clock_i(clk), .reset_i(rst), .start_i(start), .byte_in_i(bin), .byte_valid_i(bv),
        .byte_ready_o(byte_ready), .mem_addr_o(mem_addr), .mem_data_o(mem_data), .mem_we_o(mem_we),
        .cpu_hold_o(cpu_hold), .done_o(done), .err_o(err), .word_count_o(word_count)
    );

    always #5 clk = ~clk;

    int tests = 0, fails = 0;
    function automatic void chk(string nm, logic [31:0] a, logic [31:0] e);
        tests++;
        if (a !== e) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", nm, a, e, $time);
        end
    endfunction

    // Model: a load is a stream [N, 4N data bytes, (checksum)]; position in the stream decides meaning.
    bit          busy = 0, pend = 0, m_done = 0, m_err = 0;
    int          m_wc = 0, n = 0, nacc = 0, p_addr = 0;
    logic [31:0] word = 0, p_data = 0;
    logic [7:0]  sx = 0;
    logic [31:0] wr_data[$];
    int          wr_addr[$];
    logic [31:0] words[MAXW];

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            busy = 0; pend = 0; m_done = 0; m_err = 0; m_wc = 0; nacc = 0;
        end else if (pend) begin
            pend = 0;
            m_wc++;
            if (m_wc == n) begin
`ifndef IMEM_LOADER_CHECKSUM_EN
                busy = 0; m_done = 1;
`endif
            end
        end else if (start && !busy) begin
            busy = 1; nacc = 0; m_done = 0; m_err = 0; m_wc = 0; sx = 0;
        end else if (busy && bv) begin
            if (nacc == 0) begin
                if (int'(bin) == 0 || int'(bin) > MAXW) begin m_err = 1; busy = 0; end
                else n = int'(bin);
            end else if (nacc <= 4 * n) begin
                word = (word << 8) | {24'd0, bin};
                sx   = sx ^ bin;
                if (nacc % 4 == 0) begin pend = 1; p_addr = m_wc; p_data = word; end
            end else begin
                if (bin == sx) m_done = 1; else m_err = 1;
                busy = 0;
            end
            nacc++;
        end
    end

    always @(negedge clk) begin
        chk("mem_we", 32'(mem_we), 32'(pend));
        if (pend) begin
            chk("mem_addr", 32'(mem_addr), 32'(p_addr));
            chk("mem_data", mem_data, p_data);
        end
        chk("byte_ready", 32'(byte_ready), 32'(busy && !pend));
        chk("done", 32'(done), 32'(m_done));
        chk("err", 32'(err), 32'(m_err));
        chk("cpu_hold", 32'(cpu_hold), 32'(!m_done));
        chk("word_count", 32'(word_count), 32'(m_wc));
        if (mem_we) begin
            wr_data.push_back(mem_data);
            wr_addr.push_back(int'(mem_addr));
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1;
        tick();
        start = 0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        bit ok = 0;
        bv = 0;
        repeat (gap) tick();
        bv  = 1;
        bin = b;
        for (int k = 0; k < 40 && !ok; k++) begin
            ok = byte_ready;
            tick();
        end
        bv = 0;
        if (!ok) begin
            tests++; fails++;
            $display("FAIL send_byte: byte_ready stayed 0 for 40 cycles, byte %h required to be accepted", b);
        end
    endtask

    task automatic load(input logic [7:0] len, input int glo, input int ghi, input bit bad_chk);
        logic [7:0] x = 0, b;
        pulse_start();
        send_byte(len, $urandom_range(glo, ghi));
        if (len != 0 && int'(len) <= MAXW) begin
            for (int i = 0; i < int'(len); i++)
                for (int j = 3; j >= 0; j--) begin
                    b = words[i][8*j +: 8];
                    x = x ^ b;
                    send_byte(b, $urandom_range(glo, ghi));
                end
`ifdef IMEM_LOADER_CHECKSUM_EN
            send_byte(x ^ {7'd0, bad_chk}, $urandom_range(glo, ghi));
`endif
        end
        repeat (3) tick();
    endtask

    task automatic clear_log();
        wr_data.delete();
        wr_addr.delete();
    endtask

    initial begin
        #1 rst = 1;
        tick(); tick();
        chk("rst cpu_hold", 32'(cpu_hold), 1);
        chk("rst done", 32'(done), 0);
        chk("rst err", 32'(err), 0);
        chk("rst mem_we", 32'(mem_we), 0);
        chk("rst byte_ready", 32'(byte_ready), 0);
        chk("rst word_count", 32'(word_count), 0);
        rst = 0;
        tick();

        words[0] = 32'h12345678; words[1] = 32'h9ABCDEF0;
        clear_log();
        load(8'h02, 0, 0, 0);
        chk("t2 writes", 32'(wr_data.size()), 2);
        chk("t2 data0", wr_data[0], 32'h12345678);
        chk("t2 addr0", 32'(wr_addr[0]), 0);
        chk("t2 data1", wr_data[1], 32'h9ABCDEF0);
        chk("t2 addr1", 32'(wr_addr[1]), 1);
        chk("t2 done", 32'(done), 1);
        chk("t2 cpu_hold", 32'(cpu_hold), 0);
        chk("t2 word_count", 32'(word_count), 2);

        clear_log();
        load(8'h00, 0, 1, 0);
        chk("t3 err len0", 32'(err), 1);
        chk("t3 hold len0", 32'(cpu_hold), 1);
        load(8'h41, 0, 1, 0);
        chk("t3 err len65", 32'(err), 1);
        chk("t3 ready", 32'(byte_ready), 0);
        chk("t3 writes", 32'(wr_data.size()), 0);

        words[0] = 32'hAABBCCDD;
        clear_log();
        fork
            load(8'h01, 1, 1, 0);
            begin
                repeat (3) tick();
                pulse_start();
                repeat (3) tick();
                pulse_start();
            end
        join
        chk("t4 writes", 32'(wr_data.size()), 1);
        chk("t4 data", wr_data[0], 32'hAABBCCDD);
        chk("t4 addr", 32'(wr_addr[0]), 0);
        chk("t4 done", 32'(done), 1);

        pulse_start();
        send_byte(8'h01, 0);
        send_byte(8'h11, 0);
        send_byte(8'h22, 0);
        rst = 1;
        tick();
        chk("t5 ready", 32'(byte_ready), 0);
        chk("t5 hold", 32'(cpu_hold), 1);
        chk("t5 word_count", 32'(word_count), 0);
        chk("t5 mem_data", mem_data, 0);
        rst = 0;
        tick();
        words[0] = $urandom; words[1] = $urandom;
        load(8'h02, 0, 2, 0);
        chk("t5 reload done", 32'(done), 1);
        chk("t5 reload count", 32'(word_count), 2);

        for (int i = 0; i < MAXW; i++) words[i] = $urandom;
        load(8'd64, 0, 0, 0);
        chk("max len count", 32'(word_count), 64);
        chk("max len done", 32'(done), 1);

        for (int it = 0; it < 25; it++) begin
            int r = $urandom_range(0, 9);
            logic [7:0] len = r == 0 ? 8'd0 : r == 1 ? 8'($urandom_range(65, 255)) : 8'($urandom_range(1, 8));
            for (int i = 0; i < 8; i++) words[i] = $urandom;
            load(len, 0, 2, 1'($urandom_range(0, 1)));
        end

`ifdef IMEM_LOADER_CHECKSUM_EN
        words[0] = 32'h01020304;
        clear_log();
        load(8'h01, 0, 0, 0);
        chk("t6 done", 32'(done), 1);
        load(8'h01, 0, 0, 1);
        chk("t6 err", 32'(err), 1);
        chk("t6 hold", 32'(cpu_hold), 1);
        chk("t6 writes", 32'(wr_data.size()), 2);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
